// File: rtl/stm32_iq_bus_fifo.sv
// stm32_iq_bus_fifo: buffers multi-channel IQ frames in a FIFO and drives them
// byte-wise onto the 8-bit STM32 bus under command control (echo, stream,
// status, flush). All bus outputs are registered. A registered output shows the
// values of the state that was current in the cycle before the edge.
// Optional build macro FRAME_SEQ_EN: adds a per-frame 8-bit sequence byte ahead
// of each streamed frame and a fourth STATUS byte.
module stm32_iq_bus_fifo #(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_BYTES = 4,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  data_sync,
    input  logic [7:0]                            bus_in,
    output logic [7:0]                            bus_out,
    output logic                                  bus_oe,
    input  logic                                  iq_valid,
    input  logic [CHANNELS*2*SAMPLE_BYTES*8-1:0]  iq_data,
    input  logic [CHANNELS-1:0]                   ch_mask,
    output logic [DEPTH_LOG2:0]                   fifo_level,
    output logic                                  overflow,
    output logic [3:0]                            state_debug
);
    localparam int FW    = CHANNELS * 2 * SAMPLE_BYTES * 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [2:0]    NCH      = 3'(CHANNELS);
    localparam logic [2:0]    LAST_BI  = 3'(2 * SAMPLE_BYTES - 1);
`ifdef FRAME_SEQ_EN
    localparam logic [1:0]    ST_LAST  = 2'd3;
`else
    localparam logic [1:0]    ST_LAST  = 2'd2;
`endif

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_ECHO_RX = 4'd1, S_ECHO_TX = 4'd2, S_STREAM = 4'd3,
        S_STATUS = 4'd4, S_FLUSH = 4'd5, S_SEQ = 4'd6
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            bus_out_q, bus_out_d, echo_q, echo_d;
    logic                  bus_oe_q, bus_oe_d, overflow_q, overflow_d;
    logic [FW-1:0]         hold_q, hold_d, mem_q [DEPTH];
    logic [CHANNELS-1:0]   mask_q, mask_d;
    logic [2:0]            ch_q, ch_d, bi_q, bi_d;
    logic [1:0]            st_q, st_d;
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]         level_q, level_d;
    logic [7:0]            ovf_q, ovf_d, udr_q, udr_d;
`ifdef FRAME_SEQ_EN
    logic [7:0]            seq_cnt_q, seq_cnt_d, seq_mem_q [DEPTH];
`else
    logic                  start_q, start_d;
`endif
    logic                  pop, flush, wr, drop, full, emit;
    logic [FW-1:0]         e_frame, rd_frame;
    logic [CHANNELS-1:0]   e_mask;
    logic [2:0]            e_ch, e_bi, nxt_ch;

    // Lowest enabled channel at index >= from; NCH when none is left.
    function automatic logic [2:0] next_en(input logic [CHANNELS-1:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = NCH;
        for (int c = CHANNELS - 1; c >= 0; c--)
            if (c >= int'(from) && m[c]) r = 3'(c);
        return r;
    endfunction

    // Byte bi of channel ch in wire order: Q MSB-first, then I MSB-first.
    function automatic logic [7:0] frame_byte(input logic [FW-1:0] f, input logic [2:0] ch,
                                              input logic [2:0] bi);
        int idx;
        logic [7:0] r;
        r = 8'h00;
        if (int'(ch) < CHANNELS) begin
            if (int'(bi) < SAMPLE_BYTES) idx = int'(ch) * 2 * SAMPLE_BYTES + SAMPLE_BYTES - 1 - int'(bi);
            else                         idx = int'(ch) * 2 * SAMPLE_BYTES + 3 * SAMPLE_BYTES - 1 - int'(bi);
            r = f[idx*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Command decode, per-state outputs, stream cursor and FIFO bookkeeping.
    always_comb begin
        state_d = state_q;   bus_out_d = bus_out_q; bus_oe_d = 1'b0;    echo_d = echo_q;
        hold_d = hold_q;     mask_d = mask_q;       ch_d = ch_q;        bi_d = bi_q;
        st_d = st_q;         ovf_d = ovf_q;         udr_d = udr_q;      overflow_d = overflow_q;
        pop = 1'b0;          flush = 1'b0;          emit = 1'b0;
        e_frame = hold_q;    e_mask = mask_q;       e_ch = ch_q;        e_bi = bi_q;
        nxt_ch = ch_q;       rd_frame = mem_q[tail_q];
`ifdef FRAME_SEQ_EN
        seq_cnt_d = seq_cnt_q + 8'(iq_valid);
`else
        start_d = start_q;
`endif
        if (data_sync) begin
            // A command preempts whatever state was running; a partial frame is dropped.
            case (bus_in)
                8'h00:   state_d = S_ECHO_RX;
`ifdef FRAME_SEQ_EN
                8'h04:   state_d = S_SEQ;
`else
                8'h04:   begin state_d = S_STREAM; start_d = 1'b1; end
`endif
                8'h09:   begin state_d = S_STATUS; st_d = 2'd0; end
                8'h0A:   state_d = S_FLUSH;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ECHO_RX: begin echo_d = bus_in; state_d = S_ECHO_TX; end
                S_ECHO_TX: begin bus_out_d = echo_q; bus_oe_d = 1'b1; state_d = S_ECHO_RX; end
                S_STATUS: begin
                    bus_oe_d = 1'b1;
                    st_d = st_q + 2'd1;
                    case (st_q)
                        2'd0: bus_out_d = 8'(level_q);
                        2'd1: bus_out_d = ovf_q;
                        2'd2: begin
                            bus_out_d = udr_q;
                            ovf_d = 8'h00; udr_d = 8'h00; overflow_d = 1'b0;
                        end
`ifdef FRAME_SEQ_EN
                        default: bus_out_d = seq_cnt_q;
`else
                        default: bus_out_d = 8'h00;
`endif
                    endcase
                    if (st_q == ST_LAST) state_d = S_IDLE;
                end
                S_FLUSH: begin flush = 1'b1; state_d = S_IDLE; end
`ifdef FRAME_SEQ_EN
                S_SEQ: begin
                    // Frame start: load the frame and send its sequence byte first.
                    bus_oe_d = 1'b1;
                    if (ch_mask == '0) bus_out_d = 8'h00;
                    else begin
                        mask_d = ch_mask; ch_d = next_en(ch_mask, 3'd0); bi_d = 3'd0;
                        state_d = S_STREAM;
                        if (level_q != '0) begin
                            pop = 1'b1; hold_d = rd_frame; bus_out_d = seq_mem_q[tail_q];
                        end else begin
                            hold_d = '0; bus_out_d = 8'hFF; udr_d = sat_inc(udr_q);
                        end
                    end
                end
                S_STREAM: begin bus_oe_d = 1'b1; emit = 1'b1; end
`else
                S_STREAM: begin
                    // At frame start the first byte comes straight from the popped frame.
                    bus_oe_d = 1'b1;
                    if (!start_q) emit = 1'b1;
                    else if (ch_mask == '0) bus_out_d = 8'h00;
                    else begin
                        emit = 1'b1; e_mask = ch_mask; mask_d = ch_mask;
                        e_ch = next_en(ch_mask, 3'd0); e_bi = 3'd0;
                        if (level_q != '0) begin pop = 1'b1; e_frame = rd_frame; end
                        else begin e_frame = '0; udr_d = sat_inc(udr_q); end
                        hold_d = e_frame;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        if (emit) begin
            bus_out_d = frame_byte(e_frame, e_ch, e_bi);
`ifndef FRAME_SEQ_EN
            start_d = 1'b0;
`endif
            if (e_bi != LAST_BI) begin
                ch_d = e_ch; bi_d = e_bi + 3'd1;
            end else begin
                nxt_ch = next_en(e_mask, e_ch + 3'd1);
                ch_d = nxt_ch; bi_d = 3'd0;
                if (nxt_ch == NCH) begin
`ifdef FRAME_SEQ_EN
                    state_d = S_SEQ;
`else
                    start_d = 1'b1;
`endif
                end
            end
        end
        // A pop or flush in the same cycle frees room for the incoming frame.
        full = (level_q == FULL_LVL);
        wr   = iq_valid && (!full || pop || flush);
        drop = iq_valid && !wr;
        if (drop) begin ovf_d = sat_inc(ovf_d); overflow_d = 1'b1; end
        head_d = head_q + DEPTH_LOG2'(wr);
        if (flush) begin
            tail_d  = head_q;
            level_d = LW'(wr);
        end else begin
            tail_d  = tail_q + DEPTH_LOG2'(pop);
            level_d = level_q + LW'(wr) - LW'(pop);
        end
    end

    // Control and bus-output registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;  bus_out_q <= 8'h00; bus_oe_q <= 1'b0; overflow_q <= 1'b0;
            mask_q <= '0;       ch_q <= 3'd0;       bi_q <= 3'd0;     st_q <= 2'd0;
            head_q <= '0;       tail_q <= '0;       level_q <= '0;
            ovf_q <= 8'h00;     udr_q <= 8'h00;
`ifdef FRAME_SEQ_EN
            seq_cnt_q <= 8'h00;
`else
            start_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d; bus_out_q <= bus_out_d; bus_oe_q <= bus_oe_d; overflow_q <= overflow_d;
            mask_q <= mask_d;   ch_q <= ch_d;           bi_q <= bi_d;         st_q <= st_d;
            head_q <= head_d;   tail_q <= tail_d;       level_q <= level_d;
            ovf_q <= ovf_d;     udr_q <= udr_d;
`ifdef FRAME_SEQ_EN
            seq_cnt_q <= seq_cnt_d;
`else
            start_q <= start_d;
`endif
        end
    end

    // Payload storage: FIFO memory, frame hold and echo byte carry no reset.
    always_ff @(posedge clk_in) begin
        echo_q <= echo_d;
        hold_q <= hold_d;
        if (wr) mem_q[head_q] <= iq_data;
`ifdef FRAME_SEQ_EN
        if (wr) seq_mem_q[head_q] <= seq_cnt_q;
`endif
    end

    assign bus_out     = bus_out_q;
    assign bus_oe      = bus_oe_q;
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;
    assign state_debug = state_q;
endmodule
